// File: rtl/id_pkg.sv
// Shared constants, the decoded bundle type and the legality check for the decode stage.
package id_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_SUB    = 7'h20;
  localparam logic [2:0] F3_ADDSUB = 3'd0;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic            illegal;
  } id_bundle_t;

  // Only ADD, SUB, OR and AND are executable by the downstream ALU.
  function automatic logic is_legal(input logic [6:0] opcode,
                                    input logic [2:0] funct3,
                                    input logic [6:0] funct7);
    logic ok;
    ok = 1'b0;
    if (opcode == OPC_OP) begin
      ok = ((funct3 == F3_ADDSUB) && (funct7 == F7_BASE || funct7 == F7_SUB)) ||
           ((funct3 == F3_OR)     && (funct7 == F7_BASE)) ||
           ((funct3 == F3_AND)    && (funct7 == F7_BASE));
    end
    return ok;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32x64 register file: two asynchronous read ports, one synchronous write port, x0 hardwired to zero.
module regfile_2r1w
  import id_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [NREG];

  // NOTE: the array is reset because architectural state must read zero after reset,
  // which forces a flop-based implementation instead of an SRAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: R-type decode, busy scoreboard with RAW stall,
// writeback read bypass and a registered valid/ready output bundle.
module id_stage
  import id_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic            out_illegal,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic            legal, wbhit1, wbhit2, hazard, accept;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic [NREG-1:0] busy, busy_next;
  id_bundle_t      bundle_d, out_q;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign legal  = is_legal(opcode, funct3, funct7);

  regfile_2r1w u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  // A writeback in flight this cycle resolves the dependency, so it neither stalls nor reads stale data.
  assign wbhit1   = wb_en && (wb_rd == rs1);
  assign wbhit2   = wb_en && (wb_rd == rs2);
  assign hazard   = in_valid && ((busy[rs1] && !wbhit1) || (busy[rs2] && !wbhit2));
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    bundle_d         = '0;
    bundle_d.rs1_val = (wbhit1 && wb_rd != 5'd0) ? wb_data : rf_rdata1;
    bundle_d.rs2_val = (wbhit2 && wb_rd != 5'd0) ? wb_data : rf_rdata2;
    bundle_d.funct3  = funct3;
    bundle_d.funct7  = funct7;
    bundle_d.rd      = rd;
    bundle_d.illegal = !legal;
  end

  // Clear before set so a same-cycle set and clear of one index leaves it busy.
  always_comb begin
    busy_next = busy;
    if (wb_en) busy_next[wb_rd] = 1'b0;
    if (accept && legal && rd != 5'd0) busy_next[rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        out_q     <= bundle_d;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign out_rs1_val = out_q.rs1_val;
  assign out_rs2_val = out_q.rs2_val;
  assign out_funct3  = out_q.funct3;
  assign out_funct7  = out_q.funct7;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: decode, RAW stall with bypass, output stall,
// illegal handling, x0 behaviour, same-cycle set/clear and asynchronous reset.
module tb_id_stage;
  import id_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] out_rs1_val, out_rs2_val, wb_data;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd, wb_rd;
  logic            out_illegal, wb_en;
  int              checks = 0;
  int              errors = 0;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_rs1_val(out_rs1_val),
    .out_rs2_val(out_rs2_val), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_illegal(out_illegal), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] r2,
                                        input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, r2, r1, f3, d, 7'b0110011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", out_valid); end
    checks++; if (out_rs1_val !== '0 || out_rs2_val !== '0) begin errors++; $display("FAIL rst_ops got %0h %0h exp 0", out_rs1_val, out_rs2_val); end
    checks++; if ({out_funct3, out_funct7, out_rd, out_illegal} !== '0) begin errors++; $display("FAIL rst_fields got %0h exp 0", {out_funct3, out_funct7, out_rd, out_illegal}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h exp 1", in_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd5; step();
    wb_rd = 5'd2; wb_data = 64'd3; step();
    wb_en = 1'b0;
    in_valid = 1'b1; instr = 32'h002081B3; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %0h exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %0h exp 1", out_valid); end
    checks++; if (out_rs1_val !== 64'd5 || out_rs2_val !== 64'd3) begin errors++; $display("FAIL add_ops got %0h %0h exp 5 3", out_rs1_val, out_rs2_val); end
    checks++; if (out_funct3 !== 3'd0 || out_funct7 !== 7'd0 || out_rd !== 5'd3 || out_illegal !== 1'b0) begin errors++; $display("FAIL add_fields got f3=%0h f7=%0h rd=%0h ill=%0h exp 0 0 3 0", out_funct3, out_funct7, out_rd, out_illegal); end
  endtask

  task automatic test_raw_bypass();
    in_valid = 1'b1; instr = 32'h40118233; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %0h exp 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL raw_drain got valid=%0h rdy=%0h exp 0 0", out_valid, in_ready); end
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'd8; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_wb_ready got %0h exp 1", in_ready); end
    step();
    wb_en = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rs1_val !== 64'd8 || out_rs2_val !== 64'd5) begin errors++; $display("FAIL sub_ops got v=%0h %0h %0h exp 1 8 5", out_valid, out_rs1_val, out_rs2_val); end
    checks++; if (out_funct7 !== 7'h20 || out_rd !== 5'd4 || out_illegal !== 1'b0) begin errors++; $display("FAIL sub_fields got f7=%0h rd=%0h ill=%0h exp 20 4 0", out_funct7, out_rd, out_illegal); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got %0h exp 0", i, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_rd !== 5'd4 || out_rs1_val !== 64'd8) begin errors++; $display("FAIL hold_bundle[%0d] got v=%0h rd=%0h rs1=%0h exp 1 4 8", i, out_valid, out_rd, out_rs1_val); end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %0h exp 1", in_ready); end
    step();
    checks++; if (out_rd !== 5'd5 || out_rs1_val !== 64'd5 || out_rs2_val !== 64'd3) begin errors++; $display("FAIL release_bundle got rd=%0h %0h %0h exp 5 5 3", out_rd, out_rs1_val, out_rs2_val); end
    instr = rtype(7'h00, 5'd2, 5'd3, 3'd6, 5'd6); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL or_ready got %0h exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_rs1_val !== 64'd8 || out_rs2_val !== 64'd3 || out_funct3 !== 3'd6 || out_rd !== 5'd6) begin errors++; $display("FAIL or_bundle got %0h %0h f3=%0h rd=%0h exp 8 3 6 6", out_rs1_val, out_rs2_val, out_funct3, out_rd); end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; instr = 32'h00000013;
    step();
    checks++; if (out_illegal !== 1'b1 || out_valid !== 1'b1 || out_rd !== 5'd0 || out_funct3 !== 3'd0) begin errors++; $display("FAIL addi_fields got ill=%0h v=%0h rd=%0h f3=%0h exp 1 1 0 0", out_illegal, out_valid, out_rd, out_funct3); end
    instr = rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd9);
    step();
    checks++; if (out_illegal !== 1'b1 || out_funct7 !== 7'h01 || out_rd !== 5'd9) begin errors++; $display("FAIL mul_fields got ill=%0h f7=%0h rd=%0h exp 1 1 9", out_illegal, out_funct7, out_rd); end
    instr = rtype(7'h00, 5'd1, 5'd9, 3'd0, 5'd10); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_no_busy got %0h exp 1", in_ready); end
    step();
    checks++; if (out_rs1_val !== 64'd0 || out_rs2_val !== 64'd5 || out_illegal !== 1'b0) begin errors++; $display("FAIL x9_read got %0h %0h ill=%0h exp 0 5 0", out_rs1_val, out_rs2_val, out_illegal); end
    instr = rtype(7'h00, 5'd2, 5'd0, 3'd7, 5'd11);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFFFF;
    step();
    wb_en = 1'b0;
    checks++; if (out_rs1_val !== 64'd0 || out_rs2_val !== 64'd3 || out_funct3 !== 3'd7) begin errors++; $display("FAIL x0_bypass got %0h %0h f3=%0h exp 0 3 7", out_rs1_val, out_rs2_val, out_funct3); end
    instr = rtype(7'h00, 5'd0, 5'd0, 3'd7, 5'd12);
    step();
    in_valid = 1'b0;
    checks++; if (out_rs1_val !== 64'd0 || out_rs2_val !== 64'd0 || out_rd !== 5'd12) begin errors++; $display("FAIL x0_read got %0h %0h rd=%0h exp 0 0 c", out_rs1_val, out_rs2_val, out_rd); end
  endtask

  task automatic test_same_cycle();
    in_valid = 1'b1; instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
    step();
    wb_en = 1'b0;
    checks++; if (out_rs1_val !== 64'd5 || out_rs2_val !== 64'd3 || out_rd !== 5'd7) begin errors++; $display("FAIL x7_issue got %0h %0h rd=%0h exp 5 3 7", out_rs1_val, out_rs2_val, out_rd); end
    instr = rtype(7'h00, 5'd1, 5'd7, 3'd0, 5'd8); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL x7_busy_stall got %0h exp 0", in_ready); end
    checks++; if (dut.busy[7] !== 1'b1) begin errors++; $display("FAIL x7_busy got %0h exp 1", dut.busy[7]); end
    checks++; if (dut.u_regfile.regs[7] !== 64'h77) begin errors++; $display("FAIL x7_written got %0h exp 77", dut.u_regfile.regs[7]); end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; instr = rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd13);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dut.busy[5] !== 1'b1) begin errors++; $display("FAIL pre_rst got v=%0h b5=%0h exp 1 1", out_valid, dut.busy[5]); end
    #2 rst = 1'b1; #1;
    checks++; if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_rs1_val !== '0) begin errors++; $display("FAIL async_rst got v=%0h rd=%0h rs1=%0h exp 0 0 0", out_valid, out_rd, out_rs1_val); end
    checks++; if (dut.busy !== '0) begin errors++; $display("FAIL async_rst_busy got %0h exp 0", dut.busy); end
    step();
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; instr = rtype(7'h00, 5'd5, 5'd1, 3'd0, 5'd14); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0h exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_rs1_val !== '0 || out_rs2_val !== '0 || out_rd !== 5'd14) begin errors++; $display("FAIL post_rst_read got %0h %0h rd=%0h exp 0 0 e", out_rs1_val, out_rs2_val, out_rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw_bypass();
    test_back_to_back();
    test_illegal();
    test_same_cycle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
